if_fetch_stage: RTL



---
 rtl/if_fetch_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem request/response
// handshake and holds each fetched instruction until downstream accepts it.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h6000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_ir
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_WAIT_DS = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]      state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] req_addr, req_addr_n;
  logic [XLEN-1:0] pend_pc, pend_pc_n;
  logic [XLEN-1:0] pend_ir, pend_ir_n;
  logic            out_valid_n;
  logic [XLEN-1:0] out_pc_n, out_ir_n;

  logic            consume;
  logic            buf_free;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc_inc;

  assign consume      = out_valid && !stall;
  assign buf_free     = !out_valid || consume;
  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign pc_inc       = XLEN'(pc + XLEN'(4));

  // While discarding, the abandoned request must keep its original address.
  assign imem_read    = !rst && (state != S_WAIT_DS);
  assign imem_address = (state == S_DISCARD) ? req_addr : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      req_addr  <= '0;
      pend_pc   <= '0;
      pend_ir   <= '0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_ir    <= NOP_INSN;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_addr  <= req_addr_n;
      pend_pc   <= pend_pc_n;
      pend_ir   <= pend_ir_n;
      out_valid <= out_valid_n;
      out_pc    <= out_pc_n;
      out_ir    <= out_ir_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_addr_n  = req_addr;
    pend_pc_n   = pend_pc;
    pend_ir_n   = pend_ir;
    out_valid_n = out_valid;
    out_pc_n    = out_pc;
    out_ir_n    = out_ir;

    case (state)
      S_FETCH: begin
        req_addr_n = pc;
        if (redirect) begin
          // Flush the buffer; an in-flight request must still be drained.
          pc_n        = redirect_tgt;
          out_valid_n = 1'b0;
          out_pc_n    = '0;
          out_ir_n    = NOP_INSN;
          state_n     = imem_resp ? S_FETCH : S_DISCARD;
        end else if (imem_resp) begin
          pc_n = pc_inc;
          if (buf_free) begin
            out_valid_n = 1'b1;
            out_pc_n    = pc;
            out_ir_n    = imem_rdata;
          end else begin
            pend_pc_n = pc;
            pend_ir_n = imem_rdata;
            state_n   = S_WAIT_DS;
          end
        end else if (consume) begin
          out_valid_n = 1'b0;
          out_pc_n    = '0;
          out_ir_n    = NOP_INSN;
        end
      end

      S_WAIT_DS: begin
        if (redirect) begin
          pc_n        = redirect_tgt;
          out_valid_n = 1'b0;
          out_pc_n    = '0;
          out_ir_n    = NOP_INSN;
          state_n     = S_FETCH;
        end else if (consume) begin
          out_pc_n = pend_pc;
          out_ir_n = pend_ir;
          state_n  = S_FETCH;
        end
      end

      S_DISCARD: begin
        if (redirect) begin
          pc_n = redirect_tgt;
        end
        if (imem_resp) begin
          state_n = S_FETCH;
        end
      end

      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

endmodule
